// File: rtl/usrt_pkg.sv
// Shared USRT definitions used by both the receive and transmit sides.
package usrt_pkg;

  // Deframer FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } usrt_state_e;

  localparam int unsigned USRT_DATA_W   = 8;
  // Level of an idle line; the stop bit must also be at this level
  localparam logic        USRT_IDLE_LVL = 1'b1;

endpackage

// File: rtl/usrt_rx_if.sv
// Serial line inputs and parallel receive outputs of the USRT receiver.
interface usrt_rx_if
  import usrt_pkg::*;
#(
  parameter int unsigned DATA_W = USRT_DATA_W
);

  logic              sclk;
  logic              sdin;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ld;
  logic              frame_err;
  logic              busy;

  // Line driver / result consumer side
  modport master (
    output sclk,
    output sdin,
    input  rx_data,
    input  rx_ld,
    input  frame_err,
    input  busy
  );

  // Receiver side
  modport slave (
    input  sclk,
    input  sdin,
    output rx_data,
    output rx_ld,
    output frame_err,
    output busy
  );

endinterface

// File: rtl/usrt_sync_edge.sv
// Multi-flop synchronizer with a registered rising-edge strobe.
// The strobe is taken from the last two stages, so it is high in the same cycle that the
// new level first appears on sync_out.
module usrt_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rise_q;

  // Shift chain plus edge detector; stage 0 is nearest the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      rise_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = rise_q;

endmodule

// File: rtl/usrt_rx.sv
// USRT receive deframer: start bit, DATA_W data bits LSB first, one stop bit.
// Good frames produce a one-cycle rx_ld with the byte on rx_data; a low stop bit
// produces a one-cycle frame_err and leaves rx_data untouched.
module usrt_rx
  import usrt_pkg::*;
#(
  parameter int unsigned DATA_W      = USRT_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      rst,
  usrt_rx_if.slave bus
);

  localparam int unsigned           CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_W - 1);

  logic sclk_rise;
  logic sclk_level;
  logic sdin_bit;
  logic sdin_rise;

  usrt_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_ld_q, rx_ld_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;

  usrt_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_sclk (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.sclk),
    .sync_out (sclk_level),
    .rise     (sclk_rise)
  );

  // Same depth as sclk so sdin_bit is the level present at the sclk rising edge
  usrt_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_sdin (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.sdin),
    .sync_out (sdin_bit),
    .rise     (sdin_rise)
  );

  // Each synchronizer only drives one useful output
  logic unused_sync;
  assign unused_sync = sclk_level ^ sdin_rise;

  // Next-state and output decode; nothing but the pulses changes without sclk_rise
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_ld_d     = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;

    if (sclk_rise) begin
      unique case (state_q)
        ST_IDLE: begin
          if (sdin_bit != USRT_IDLE_LVL) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        ST_DATA: begin
          shreg_d[cnt_q] = sdin_bit;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (sdin_bit == USRT_IDLE_LVL) begin
            rx_data_d = shreg_q;
            rx_ld_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          // The stop bit is never reinterpreted as a start bit
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, counter, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_ld_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_ld_q     <= rx_ld_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_ld     = rx_ld_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_usrt_rx.sv
// Directed bench for usrt_rx: sclk = clk/8, sdin changes with the sclk falling edge.
module tb_usrt_rx;
  import usrt_pkg::*;

  logic clk;
  logic rst;
  int   cyc;

  int n_checks;
  int n_fail;

  // Pulse monitor results
  int          ld_cnt;
  int          fe_cnt;
  int          overlap_cnt;
  int          busy_hi_cnt;
  logic [7:0]  ld_data_q[$];
  int          ld_cyc_q[$];

  usrt_rx_if #(.DATA_W(8)) bus ();

  usrt_rx #(
    .DATA_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs only change on posedge, so observe them on negedge
  always @(negedge clk) begin
    if (bus.rx_ld === 1'b1) begin
      ld_cnt++;
      ld_data_q.push_back(bus.rx_data);
      ld_cyc_q.push_back(cyc);
    end
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.rx_ld === 1'b1 && bus.frame_err === 1'b1) overlap_cnt++;
    if (bus.busy === 1'b1) busy_hi_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One sclk period: low half with new data, then high half.
  // mode 1 probes busy around a start sample, mode 2 probes the stop sample outcome.
  task automatic send_bit(input logic b, input int mode, input logic [7:0] exp_data);
    bus.sclk = 1'b0;
    bus.sdin = b;
    repeat (4) @(negedge clk);
    bus.sclk = 1'b1;
    repeat (2) @(negedge clk);
    if (mode == 1) check_eq("busy_before_start", 32'(bus.busy), 32'd0);
    if (mode == 2) begin
      check_eq("busy_before_stop", 32'(bus.busy), 32'd1);
      check_eq("ld_before_stop", 32'(bus.rx_ld), 32'd0);
    end
    @(negedge clk);
    if (mode == 1) check_eq("busy_after_start", 32'(bus.busy), 32'd1);
    if (mode == 2) begin
      check_eq("busy_after_stop", 32'(bus.busy), 32'd0);
      check_eq("ld_after_stop", 32'(bus.rx_ld), 32'd1);
      check_eq("data_at_ld", 32'(bus.rx_data), 32'(exp_data));
    end
    @(negedge clk);
    if (mode == 2) check_eq("ld_one_cycle", 32'(bus.rx_ld), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit probe);
    send_bit(1'b0, probe ? 1 : 0, 8'h00);
    for (int i = 0; i < 8; i++) send_bit(d[i], 0, 8'h00);
    send_bit(stop_bit, probe ? 2 : 0, d);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 0, 8'h00);
  endtask

  initial begin
    int ld0, fe0, bh0, stall_lo, q0;
    n_checks    = 0;
    n_fail      = 0;
    ld_cnt      = 0;
    fe_cnt      = 0;
    overlap_cnt = 0;
    busy_hi_cnt = 0;
    cyc         = 0;
    rst         = 1'b1;
    bus.sclk    = 1'b0;
    bus.sdin    = USRT_IDLE_LVL;
    repeat (4) @(negedge clk);
    check_eq("rst_rx_data", 32'(bus.rx_data), 32'h0);
    check_eq("rst_rx_ld", 32'(bus.rx_ld), 32'd0);
    check_eq("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    idle_bits(2);

    // 1: good frame 0xA5 with busy/ld timing probes
    ld0 = ld_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_bits(2);
    check_eq("t1_ld_count", 32'(ld_cnt - ld0), 32'd1);
    check_eq("t1_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check_eq("t1_rx_data", 32'(bus.rx_data), 32'hA5);

    // 2: bad stop bit on 0x3C
    ld0 = ld_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_bits(2);
    check_eq("t2_fe_count", 32'(fe_cnt - fe0), 32'd1);
    check_eq("t2_ld_count", 32'(ld_cnt - ld0), 32'd0);
    check_eq("t2_rx_data_held", 32'(bus.rx_data), 32'hA5);
    check_eq("t2_busy", 32'(bus.busy), 32'd0);

    // 3: reset during data bit 4 of 0xFF, then 0x81
    ld0 = ld_cnt; fe0 = fe_cnt;
    send_bit(1'b0, 0, 8'h00);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0, 8'h00);
    check_eq("t3_busy_mid_frame", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t3_busy_after_rst", 32'(bus.busy), 32'd0);
    idle_bits(4);
    check_eq("t3_ld_count", 32'(ld_cnt - ld0), 32'd0);
    check_eq("t3_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check_eq("t3_busy", 32'(bus.busy), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(2);
    check_eq("t3_ld_after", 32'(ld_cnt - ld0), 32'd1);
    check_eq("t3_rx_data", 32'(bus.rx_data), 32'h81);

    // 4: back-to-back 0x00 then 0xFF
    ld0 = ld_cnt; fe0 = fe_cnt; q0 = ld_data_q.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(2);
    check_eq("t4_ld_count", 32'(ld_cnt - ld0), 32'd2);
    check_eq("t4_fe_count", 32'(fe_cnt - fe0), 32'd0);
    if (ld_data_q.size() >= q0 + 2) begin
      check_eq("t4_first", 32'(ld_data_q[q0]), 32'h00);
      check_eq("t4_second", 32'(ld_data_q[q0+1]), 32'hFF);
      check_eq("t4_spacing", 32'(ld_cyc_q[q0+1] - ld_cyc_q[q0]), 32'd80);
    end

    // 5: idle line with 40 sclk edges
    ld0 = ld_cnt; fe0 = fe_cnt; bh0 = busy_hi_cnt;
    idle_bits(40);
    check_eq("t5_ld_count", 32'(ld_cnt - ld0), 32'd0);
    check_eq("t5_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check_eq("t5_busy_cycles", 32'(busy_hi_cnt - bh0), 32'd0);

    // 6: sclk stalled after data bit 2 of 0x5A
    ld0 = ld_cnt; fe0 = fe_cnt;
    send_bit(1'b0, 0, 8'h00);
    send_bit(1'b0, 0, 8'h00);
    send_bit(1'b1, 0, 8'h00);
    send_bit(1'b0, 0, 8'h00);
    stall_lo = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) stall_lo++;
    end
    check_eq("t6_busy_stall", 32'(stall_lo), 32'd0);
    check_eq("t6_no_ld_stall", 32'(ld_cnt - ld0), 32'd0);
    send_bit(1'b1, 0, 8'h00);
    send_bit(1'b1, 0, 8'h00);
    send_bit(1'b0, 0, 8'h00);
    send_bit(1'b1, 0, 8'h00);
    send_bit(1'b0, 0, 8'h00);
    send_bit(1'b1, 0, 8'h00);
    idle_bits(2);
    check_eq("t6_ld_count", 32'(ld_cnt - ld0), 32'd1);
    check_eq("t6_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check_eq("t6_rx_data", 32'(bus.rx_data), 32'h5A);

    check_eq("ld_fe_overlap", 32'(overlap_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
